cpu_datamem_arb: RTL and testbench
==================================

CPU_DATAMEM_ARB -- requirements
Module: cpu_datamem_arb

Parameters
REQ-001 The block SHALL expose parameter ADDR_W, default 16, meaning byte-address width; memory depth is 2^ADDR_W bytes.
REQ-002 The block SHALL expose parameter BURST_WORDS, default 16, meaning 32-bit words per accelerator burst read (16 gives 64 bytes).

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_addr  input  ADDR_W  CPU byte address.
REQ-006 cpu_wrt_en  input  1  CPU 4-byte write request.
REQ-007 cpu_wrt_data  input  32  CPU write data, byte 0 = bits [7:0].
REQ-008 cpu_rd_en  input  1  CPU 4-byte read request.
REQ-009 cpu_rd_data  output  32  CPU read data.
REQ-010 cpu_rd_valid  output  1  pulse qualifying cpu_rd_data.
REQ-011 accel_addr  input  ADDR_W  accelerator byte address, write or burst base.
REQ-012 accel_wrt_en  input  1  accelerator 4-byte write request, held until acked.
REQ-013 accel_wrt_data  input  32  accelerator write data, little-endian.
REQ-014 accel_wrt_ack  output  1  pulse; accelerator write committed this edge.
REQ-015 accel_rd_req  input  1  start burst read at accel_addr.
REQ-016 accel_busy  output  1  burst in progress.
REQ-017 accel_rd_data  output  32*BURST_WORDS  burst data, word k at bits [32k+:32].
REQ-018 accel_rd_valid  output  1  pulse; accel_rd_data complete.
REQ-019 err  output  1  registered one-cycle error pulse.

Function
REQ-020 The array SHALL be byte-addressed and little-endian: a word at address A occupies bytes A..A+3, LSB at A.
REQ-021 The array SHALL be single-ported: at most one 4-byte access (read or write) per cycle.
REQ-022 Arbitration: CPU access > accelerator write > burst beat; a losing accelerator access waits without loss.
REQ-023 CPU read: data SHALL appear on cpu_rd_data with cpu_rd_valid high exactly 1 cycle after cpu_rd_en is sampled; cpu_rd_data holds its value otherwise.
REQ-024 CPU write: bytes SHALL update at the sampling edge; a read of the same address on the next cycle returns the new data.
REQ-025 cpu_wrt_en and cpu_rd_en together: write performed, read dropped, cpu_rd_valid stays low, err pulses.
REQ-026 accel_wrt_en SHALL be acked only in IDLE with no CPU access that cycle; accel_wrt_ack pulses for one cycle.
REQ-027 Burst FSM states: IDLE, READ, DONE.
REQ-028 IDLE->READ when accel_rd_req sampled and in range; base address latched, beat counter cleared, accel_busy high from the next cycle.
REQ-029 READ: each cycle without CPU access reads word at base+4*cnt into slot cnt and increments cnt; CPU-access cycles stall cnt.
REQ-030 READ->DONE after beat BURST_WORDS-1; DONE->IDLE next cycle with accel_rd_valid high for exactly the DONE cycle.
REQ-031 Burst latency with no CPU traffic SHALL be BURST_WORDS+1 cycles from request edge to accel_rd_valid.
REQ-032 accel_rd_data SHALL hold the last completed burst until the next burst's first beat overwrites slot 0.
REQ-033 accel_rd_req while not IDLE SHALL be ignored, with no err.
REQ-034 Range check: a CPU or accel word access with addr > 2^ADDR_W-4, or a burst with base > 2^ADDR_W-4*BURST_WORDS, SHALL be rejected with no memory effect and err pulsed the next cycle; rejected accel writes are still acked.
REQ-035 Bursts SHALL return snapshot-per-beat data: a CPU write to a not-yet-read word is visible to the burst.

Reset
REQ-036 rst SHALL force FSM to IDLE, beat counter 0, cpu_rd_data 0, cpu_rd_valid 0, accel_busy 0, accel_rd_data 0, accel_rd_valid 0, accel_wrt_ack 0, err 0.
REQ-037 Array contents SHALL NOT be reset; rst mid-burst SHALL abort the burst with no accel_rd_valid.

Verification
REQ-038 CPU write 0xDEADBEEF @0x1000, read @0x1000 -> cpu_rd_data 0xDEADBEEF 1 cycle later; byte read @0x1001 yields 0x??DEADBE with byte 0x1004 in MSB.
REQ-039 Fill 0x5000..0x503F with word k = k, accel_rd_req @0x5000, idle CPU -> accel_rd_valid at cycle 17, word k = k.
REQ-040 Same burst with CPU reads on 3 cycles mid-burst -> accel_rd_valid at cycle 20, data unchanged, CPU reads correct.
REQ-041 Simultaneous cpu_wrt_en @0x2000 and accel_wrt_en @0x2100 -> CPU write this cycle, accel_wrt_ack next cycle, both words stored.
REQ-042 cpu_rd_en @0xFFFD, accel_rd_req @0xFFC4 -> err pulses each, no burst starts, no cpu_rd_valid.
REQ-043 rst asserted at beat 8 of a burst -> all outputs 0 immediately, no accel_rd_valid, next burst completes normally.

Source files
------------

// File: rtl/cpu_datamem_arb_if.sv
// CPU / accelerator data-memory bus bundle.
// master drives requests, slave (the arbiter) returns data, acks and err.
interface cpu_datamem_arb_if #(
  parameter int ADDR_W      = 16,
  parameter int BURST_WORDS = 16
);
  logic [ADDR_W-1:0]         cpu_addr;
  logic                      cpu_wrt_en;
  logic [31:0]               cpu_wrt_data;
  logic                      cpu_rd_en;
  logic [31:0]               cpu_rd_data;
  logic                      cpu_rd_valid;
  logic [ADDR_W-1:0]         accel_addr;
  logic                      accel_wrt_en;
  logic [31:0]               accel_wrt_data;
  logic                      accel_wrt_ack;
  logic                      accel_rd_req;
  logic                      accel_busy;
  logic [32*BURST_WORDS-1:0] accel_rd_data;
  logic                      accel_rd_valid;
  logic                      err;

  modport master (
    output cpu_addr, cpu_wrt_en, cpu_wrt_data, cpu_rd_en,
    output accel_addr, accel_wrt_en, accel_wrt_data, accel_rd_req,
    input  cpu_rd_data, cpu_rd_valid, accel_wrt_ack,
    input  accel_busy, accel_rd_data, accel_rd_valid, err
  );

  modport slave (
    input  cpu_addr, cpu_wrt_en, cpu_wrt_data, cpu_rd_en,
    input  accel_addr, accel_wrt_en, accel_wrt_data, accel_rd_req,
    output cpu_rd_data, cpu_rd_valid, accel_wrt_ack,
    output accel_busy, accel_rd_data, accel_rd_valid, err
  );
endinterface

// File: rtl/cpu_datamem_arb.sv
// Single-port byte-addressed data memory shared by CPU and accelerator.
// Ports: clk, rst (async high), bus (slave side of cpu_datamem_arb_if).
module cpu_datamem_arb #(
  parameter int ADDR_W      = 16,
  parameter int BURST_WORDS = 16
) (
  input logic              clk,
  input logic              rst,
  cpu_datamem_arb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(BURST_WORDS);

  localparam logic [ADDR_W-1:0] LAST_W = '1 - ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LAST_B =
    '1 - ADDR_W'(4 * BURST_WORDS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(BURST_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0] mem [0:DEPTH-1];

  logic [CW-1:0]             cnt;
  logic [ADDR_W-1:0]         base;
  logic [31:0]               rd_data;
  logic                      rd_valid;
  logic [32*BURST_WORDS-1:0] slots;
  logic                      err_q;

  logic              cpu_act, cpu_ok, acc_ok, brst_ok;
  logic              grant, start, beat, cpu_rd_go;
  logic              wr_go, err_d, busy, done;
  logic [ADDR_W-1:0] wr_addr, rd_addr, beat_addr;
  logic [31:0]       wr_data, rd_word;

  assign cpu_act = bus.cpu_wrt_en | bus.cpu_rd_en;
  assign cpu_ok  = bus.cpu_addr <= LAST_W;
  assign acc_ok  = bus.accel_addr <= LAST_W;
  assign brst_ok = bus.accel_addr <= LAST_B;

  // CPU owns the port whenever it asks; accel write next, beat last
  assign grant = (state == IDLE) & ~cpu_act & bus.accel_wrt_en;
  assign start = (state == IDLE) & bus.accel_rd_req & brst_ok;
  assign beat  = (state == READ) & ~cpu_act;

  assign cpu_rd_go = bus.cpu_rd_en & ~bus.cpu_wrt_en & cpu_ok;

  assign err_d =
    (bus.cpu_wrt_en & bus.cpu_rd_en) |
    (cpu_act & ~cpu_ok) |
    (grant & ~acc_ok) |
    ((state == IDLE) & bus.accel_rd_req & ~brst_ok);

  assign beat_addr = base + ADDR_W'({cnt, 2'b00});
  assign rd_addr   = cpu_act ? bus.cpu_addr : beat_addr;

  always_comb begin
    wr_go   = 1'b0;
    wr_addr = bus.cpu_addr;
    wr_data = bus.cpu_wrt_data;
    if (bus.cpu_wrt_en & cpu_ok) begin
      wr_go = 1'b1;
    end else if (grant & acc_ok) begin
      wr_go   = 1'b1;
      wr_addr = bus.accel_addr;
      wr_data = bus.accel_wrt_data;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++)
      rd_word[8*k +: 8] = mem[rd_addr + ADDR_W'(k)];
  end

  // array contents survive reset
  always_ff @(posedge clk) begin
    if (wr_go)
      for (int k = 0; k < 4; k++)
        mem[wr_addr + ADDR_W'(k)] <= wr_data[8*k +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (beat && cnt == LAST_C) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:    ;
      READ:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      base     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      slots    <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_valid <= cpu_rd_go;
      err_q    <= err_d;
      if (cpu_rd_go) rd_data <= rd_word;
      if (start) begin
        base <= bus.accel_addr;
        cnt  <= '0;
      end else if (beat) begin
        slots[32*cnt +: 32] <= rd_word;
        cnt <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign bus.cpu_rd_data    = rd_data;
  assign bus.cpu_rd_valid   = rd_valid;
  assign bus.accel_wrt_ack  = grant & ~rst;
  assign bus.accel_busy     = busy;
  assign bus.accel_rd_data  = slots;
  assign bus.accel_rd_valid = done;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_cpu_datamem_arb.sv
// Directed bench for cpu_datamem_arb with CPU-read and burst scoreboards.
// A byte-level memory model supplies every expected read value.
module tb_cpu_datamem_arb;

  localparam int AW = 16;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cpu_datamem_arb_if #(.ADDR_W(AW), .BURST_WORDS(BW)) bus ();

  cpu_datamem_arb #(.ADDR_W(AW), .BURST_WORDS(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]   model [0:65535];
  logic [31:0]  cq [$];
  logic [511:0] bq [$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int err_cnt = 0;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [15:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = model[16'(a + k)];
    return w;
  endfunction

  function automatic logic [511:0] mburst(input logic [15:0] b);
    logic [511:0] r;
    for (int k = 0; k < BW; k++) r[32*k +: 32] = mword(16'(b + 4*k));
    return r;
  endfunction

  task automatic mset(input logic [15:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) model[16'(a + k)] = d[8*k +: 8];
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_wrt_en   = 1'b0;
    bus.cpu_rd_en    = 1'b0;
    bus.accel_wrt_en = 1'b0;
    bus.accel_rd_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    mset(a, d);
    bus.cpu_addr     = a;
    bus.cpu_wrt_data = d;
    bus.cpu_wrt_en   = 1'b1;
    bus.cpu_rd_en    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus.cpu_addr   = a;
    bus.cpu_wrt_en = 1'b0;
    bus.cpu_rd_en  = 1'b1;
    cq.push_back(mword(a));
  endtask

  // mode 0 quiet, 1 three CPU reads, 2 CPU write + busy req, 3 stop at beat 8
  task automatic burst(input logic [15:0] b, input int mode,
                       output int lat);
    bus.accel_addr   = b;
    bus.accel_rd_req = 1'b1;
    if (mode != 3) bq.push_back(mburst(b));
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      nxt();
      idle();
      if (bus.accel_rd_valid) begin
        lat = n;
        break;
      end
      if (mode == 3 && n == 8) break;
      if (mode == 1 && n == 3)  rd(16'h5008);
      if (mode == 1 && n == 4)  rd(16'h503C);
      if (mode == 1 && n == 10) rd(16'h1000);
      if (mode == 2 && n == 2) begin
        bus.cpu_addr     = 16'h503C;
        bus.cpu_wrt_data = 32'hCAFEF00D;
        bus.cpu_wrt_en   = 1'b1;
      end
      if (mode == 2 && n == 4) begin
        bus.accel_addr   = 16'hFFC4;
        bus.accel_rd_req = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.err) err_cnt++;
    if (bus.cpu_rd_valid) begin
      if (cq.size() == 0) chk("cpu_rd_unexpected", bus.cpu_rd_valid, 0);
      else chk("cpu_rd_data", bus.cpu_rd_data, cq.pop_front());
    end
    if (bus.accel_rd_valid) begin
      if (bq.size() == 0)
        chk("burst_unexpected", bus.accel_rd_valid, 0);
      else chk("burst_data", bus.accel_rd_data, bq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int e0;
    bus.cpu_addr       = '0;
    bus.cpu_wrt_data   = '0;
    bus.accel_addr     = '0;
    bus.accel_wrt_data = '0;
    idle();

    nxt();
    nxt();
    chk("rst_cpu_rd_data", bus.cpu_rd_data, 0);
    chk("rst_cpu_rd_valid", bus.cpu_rd_valid, 0);
    chk("rst_busy", bus.accel_busy, 0);
    chk("rst_accel_rd_data", bus.accel_rd_data, 0);
    chk("rst_accel_rd_valid", bus.accel_rd_valid, 0);
    chk("rst_ack", bus.accel_wrt_ack, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    nxt();

    wr(16'h1000, 32'hDEADBEEF);
    nxt();
    wr(16'h1004, 32'h11223344);
    nxt();
    rd(16'h1000);
    nxt();
    chk("rd_latency", bus.cpu_rd_valid, 1);
    rd(16'h1001);
    nxt();
    idle();
    nxt();
    chk("rd_hold_data", bus.cpu_rd_data, 32'h44DEADBE);
    chk("rd_valid_pulse", bus.cpu_rd_valid, 0);

    for (int k = 0; k < BW; k++) begin
      wr(16'(16'h5000 + 4*k), 32'(k));
      nxt();
    end
    idle();
    nxt();

    burst(16'h5000, 0, lat);
    chk("burst_lat_idle", lat, 17);
    nxt();
    chk("burst_valid_pulse", bus.accel_rd_valid, 0);
    chk("burst_busy_clear", bus.accel_busy, 0);
    nxt();
    chk("burst_hold", bus.accel_rd_data, mburst(16'h5000));

    burst(16'h5000, 1, lat);
    chk("burst_lat_stall3", lat, 20);
    nxt();

    mset(16'h503C, 32'hCAFEF00D);
    e0 = err_cnt;
    burst(16'h5000, 2, lat);
    chk("burst_lat_stall1", lat, 18);
    chk("busy_req_no_err", err_cnt, e0);
    nxt();

    wr(16'h2000, 32'hA5A50001);
    mset(16'h2100, 32'h5A5A0002);
    bus.accel_addr     = 16'h2100;
    bus.accel_wrt_data = 32'h5A5A0002;
    bus.accel_wrt_en   = 1'b1;
    #1;
    chk("ack_blocked_by_cpu", bus.accel_wrt_ack, 0);
    nxt();
    bus.cpu_wrt_en = 1'b0;
    #1;
    chk("ack_granted", bus.accel_wrt_ack, 1);
    nxt();
    bus.accel_wrt_en = 1'b0;
    #1;
    chk("ack_pulse", bus.accel_wrt_ack, 0);
    rd(16'h2000);
    nxt();
    rd(16'h2100);
    nxt();
    idle();
    nxt();

    bus.cpu_addr  = 16'hFFFD;
    bus.cpu_rd_en = 1'b1;
    nxt();
    idle();
    chk("err_cpu_oob", bus.err, 1);
    chk("no_valid_oob", bus.cpu_rd_valid, 0);
    nxt();
    chk("err_pulse", bus.err, 0);
    bus.accel_addr   = 16'hFFC4;
    bus.accel_rd_req = 1'b1;
    nxt();
    idle();
    chk("err_burst_oob", bus.err, 1);
    chk("no_burst_oob", bus.accel_busy, 0);
    nxt();

    wr(16'h3000, 32'h0BADF00D);
    bus.cpu_rd_en = 1'b1;
    nxt();
    idle();
    chk("err_rd_wr_both", bus.err, 1);
    chk("no_valid_both", bus.cpu_rd_valid, 0);
    rd(16'h3000);
    nxt();
    idle();
    nxt();

    bus.accel_addr     = 16'hFFFE;
    bus.accel_wrt_data = 32'h12345678;
    bus.accel_wrt_en   = 1'b1;
    #1;
    chk("ack_oob_write", bus.accel_wrt_ack, 1);
    nxt();
    idle();
    chk("err_accel_oob", bus.err, 1);
    nxt();

    wr(16'hFFFC, 32'h76543210);
    nxt();
    rd(16'hFFFC);
    nxt();
    idle();
    chk("no_err_top_word", bus.err, 0);
    nxt();

    burst(16'h5000, 3, lat);
    chk("busy_mid_burst", bus.accel_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.accel_busy, 0);
    chk("abort_valid", bus.accel_rd_valid, 0);
    chk("abort_cpu_rd_data", bus.cpu_rd_data, 0);
    chk("abort_accel_rd_data", bus.accel_rd_data, 0);
    chk("abort_err", bus.err, 0);
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    burst(16'h5000, 0, lat);
    chk("burst_lat_after_rst", lat, 17);
    nxt();
    nxt();
    nxt();

    chk("cpu_queue_drained", cq.size(), 0);
    chk("burst_queue_drained", bq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
